router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 30, consecutive unread cycles before an output FIFO is soft-reset.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pkt_valid  in  1  data_in carries a valid byte this cycle.
REQ-005 data_in  in  8  packet byte; header = {len[7:2], addr[1:0]}.
REQ-006 fifo_full  in  3  full flag per output FIFO.
REQ-007 fifo_empty  in  3  empty flag per output FIFO.
REQ-008 read_en  in  3  destination read strobe per output FIFO.
REQ-009 busy  out  1  byte on data_in not accepted this cycle; source holds it.
REQ-010 fifo_din  out  8  registered byte to FIFOs.
REQ-011 write_enb  out  3  one-hot FIFO write enable, registered.
REQ-012 lfd_state  out  1  high in header acceptance cycle.
REQ-013 vld_out  out  3  ~fifo_empty, combinational.
REQ-014 soft_rst  out  3  one-cycle per-FIFO flush pulse, registered.
REQ-015 parity_done  out  1  packet parity check complete.
REQ-016 err  out  1  parity mismatch or aborted packet.

Function
REQ-017 States: IDLE, WAIT_EMPTY, LOAD_DATA, CHECK_PARITY, DROP.
REQ-018 Packet = header, len payload bytes (len 0..63), one parity byte; pkt_valid low = stall, never truncation.
REQ-019 Header accepted iff state IDLE/WAIT_EMPTY, pkt_valid, addr!=3, fifo_empty[addr]=1, pend=0; then addr latched, lfd_state=1, byte counter=len+1, parity=header, state -> LOAD_DATA.
REQ-020 IDLE, pkt_valid, addr!=3, header not accepted -> WAIT_EMPTY, busy=1; WAIT_EMPTY holds busy=1 until acceptance.
REQ-021 IDLE, pkt_valid, addr=3 -> header consumed, counter=len+1, DROP; DROP consumes bytes with busy=0, no writes, until counter=0 -> IDLE.
REQ-022 One-entry output skid register (pend): byte accepted in cycle N appears on fifo_din with write_enb[tgt]=1 from cycle N+1; held while fifo_full[tgt]=1; cleared the cycle write occurs with fifo_full[tgt]=0.
REQ-023 LOAD_DATA accepts byte iff pkt_valid and (pend=0 or fifo_full[tgt]=0); busy = pend & fifo_full[tgt]; no byte lost or duplicated.
REQ-024 Each accepted payload byte XORed into parity, counter decremented; byte accepted at counter=0 is parity byte (also written), -> CHECK_PARITY.
REQ-025 CHECK_PARITY (one cycle, busy=1): parity_done<=1, err<=(computed!=received); both held until next header accepted, then cleared; -> IDLE.
REQ-026 Soft-reset timer per port: soft_rst[i]=1 for exactly one cycle at N+1 when cycles N-TIMEOUT+1..N all had vld_out[i]=1, read_en[i]=0; counter then restarts; any read_en[i] or fifo_empty[i] clears it.
REQ-027 soft_rst[tgt] during WAIT_EMPTY/LOAD_DATA: pend cleared, err<=1, remaining bytes consumed in DROP.
REQ-028 write_enb never has more than one bit set.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, pend=0, counters 0, all outputs 0 (busy, fifo_din, write_enb, lfd_state, soft_rst, parity_done, err) from next cycle; vld_out still follows fifo_empty.
REQ-030 rst mid-packet abandons it; no write issued after rst edge.

Structure
REQ-031 Package router_pkg holds state enum, TIMEOUT default, ADDR_DROP=2'b11, port count 3.
REQ-032 Sub-module router_sr_timer (one port's timeout counter) instantiated three times.

Verification
REQ-033 Header 8'h0D, payload 11/22/33, parity 0D, FIFO1 empty -> lfd_state header cycle, write_enb=3'b010 for 5 consecutive cycles, bytes 0D,11,22,33,0D, parity_done=1, err=0.
REQ-034 Same packet, parity 8'h00 -> err=1 after CHECK_PARITY, held until next header.
REQ-035 Header 8'h02 with fifo_empty[2]=0 for 4 cycles -> busy=1, write_enb=0; fifo_empty[2]=1 -> header accepted that cycle.
REQ-036 fifo_full[0]=1 for 3 cycles mid-payload -> fifo_din/write_enb=3'b001 held, busy=1 while pend set, all bytes written once in order.
REQ-037 fifo_empty[0]=0, read_en=0 from cycle 1 -> soft_rst[0]=1 only in cycle 31; read_en[0] pulse at cycle 29 -> no pulse until cycle 60.
REQ-038 Header 8'h0B (addr 3, len 2) -> 4 bytes consumed, write_enb=0, busy=0; rst mid LOAD_DATA -> outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the packet router controller.
package router_pkg;

    localparam int         NUM_PORTS       = 3;
    localparam int         TIMEOUT_DEFAULT = 30;
    localparam logic [1:0] ADDR_DROP       = 2'b11;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_EMPTY   = 3'd1,
        LOAD_DATA    = 3'd2,
        CHECK_PARITY = 3'd3,
        DROP         = 3'd4
    } state_t;

    // One-hot port select; the drop address maps to no port at all.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
        logic [3:0] sel;
        sel = 4'b0001 << addr;
        return sel[NUM_PORTS-1:0];
    endfunction

endpackage

// File: rtl/router_sr_timer.sv
// Per-port idle-read watchdog: pulses soft_rst for one cycle after TIMEOUT
// consecutive cycles of valid-but-unread output data.
module router_sr_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_rst
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (!vld || rd) begin
            cnt      <= '0;
            soft_rst <= 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
            cnt      <= '0;
            soft_rst <= 1'b1;
        end else begin
            cnt      <= cnt + 1'b1;
            soft_rst <= 1'b0;
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Router controller: accepts header/payload/parity packets, steers them through a
// one-entry skid register into one of three output FIFOs, and flushes stale FIFOs.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_en,
    output logic                 busy,
    output logic [7:0]           fifo_din,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_rst,
    output logic                 parity_done,
    output logic                 err
);

    state_t               state, state_nxt;
    logic [1:0]           tgt, tgt_nxt;
    logic [6:0]           cnt, cnt_nxt;
    logic [7:0]           parity, parity_nxt;
    logic                 load, abort, chk;
    logic [NUM_PORTS-1:0] load_oh;

    logic [1:0]           hdr_addr;
    logic [6:0]           hdr_cnt;
    logic [NUM_PORTS-1:0] hdr_oh, tgt_oh;
    logic                 pend, pend_full, pend_flush, hdr_ok, abort_wait, abort_load;

    assign vld_out = ~fifo_empty;

    // write_enb doubles as the skid register's occupied flag and target.
    assign hdr_addr   = data_in[1:0];
    assign hdr_cnt    = {1'b0, data_in[7:2]} + 7'd1;
    assign hdr_oh     = port_onehot(hdr_addr);
    assign tgt_oh     = port_onehot(tgt);
    assign pend       = |write_enb;
    assign pend_full  = |(write_enb & fifo_full);
    assign pend_flush = |(write_enb & soft_rst);
    assign hdr_ok     = pkt_valid && (hdr_addr != ADDR_DROP) && |(hdr_oh & fifo_empty) && !pend;
    assign abort_wait = pkt_valid && |(hdr_oh & soft_rst);
    assign abort_load = |(tgt_oh & soft_rst);

    always_comb begin
        state_nxt  = state;
        tgt_nxt    = tgt;
        cnt_nxt    = cnt;
        parity_nxt = parity;
        busy       = 1'b0;
        lfd_state  = 1'b0;
        load       = 1'b0;
        load_oh    = tgt_oh;
        abort      = 1'b0;
        chk        = 1'b0;
        case (state)
            IDLE, WAIT_EMPTY: begin
                if (state == WAIT_EMPTY && abort_wait) begin
                    // Destination was flushed under a waiting header: discard the whole packet.
                    abort     = 1'b1;
                    cnt_nxt   = hdr_cnt;
                    state_nxt = DROP;
                end else if (hdr_ok) begin
                    lfd_state  = 1'b1;
                    load       = 1'b1;
                    load_oh    = hdr_oh;
                    tgt_nxt    = hdr_addr;
                    cnt_nxt    = hdr_cnt;
                    parity_nxt = data_in;
                    state_nxt  = LOAD_DATA;
                end else if (state == IDLE && pkt_valid && hdr_addr == ADDR_DROP) begin
                    cnt_nxt   = hdr_cnt;
                    state_nxt = DROP;
                end else if (pkt_valid || state == WAIT_EMPTY) begin
                    busy      = 1'b1;
                    state_nxt = WAIT_EMPTY;
                end
            end
            LOAD_DATA: begin
                if (abort_load) begin
                    abort     = 1'b1;
                    busy      = 1'b1;
                    state_nxt = DROP;
                end else begin
                    busy = pend_full;
                    if (pkt_valid && !pend_full) begin
                        load       = 1'b1;
                        parity_nxt = parity ^ data_in;
                        cnt_nxt    = cnt - 7'd1;
                        if (cnt == 7'd1) state_nxt = CHECK_PARITY;
                    end
                end
            end
            CHECK_PARITY: begin
                busy      = 1'b1;
                chk       = 1'b1;
                state_nxt = IDLE;
            end
            DROP: begin
                if (cnt == 7'd0) begin
                    busy      = 1'b1;
                    state_nxt = IDLE;
                end else if (pkt_valid) begin
                    cnt_nxt = cnt - 7'd1;
                    if (cnt == 7'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tgt         <= 2'd0;
            cnt         <= 7'd0;
            parity      <= 8'd0;
            fifo_din    <= 8'd0;
            write_enb   <= '0;
            parity_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            state  <= state_nxt;
            tgt    <= tgt_nxt;
            cnt    <= cnt_nxt;
            parity <= parity_nxt;
            if (load) begin
                fifo_din  <= data_in;
                write_enb <= load_oh;
            end else if (pend_flush || (pend && !pend_full)) begin
                write_enb <= '0;
            end
            // parity register already folds in the received parity byte, so zero means match
            if (lfd_state) begin
                parity_done <= 1'b0;
                err         <= 1'b0;
            end else if (chk) begin
                parity_done <= 1'b1;
                err         <= (parity != 8'd0);
            end else if (abort) begin
                err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tmr
        router_sr_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
            .clk      (clk),
            .rst      (rst),
            .vld      (vld_out[i]),
            .rd       (read_en[i]),
            .soft_rst (soft_rst[i])
        );
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: packet-level reference model feeding a write/parity
// scoreboard, plus directed cycle checks around stalls, waits, timeouts and reset.
module tb_router_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_en;
    logic       busy, lfd_state, parity_done, err;
    logic [7:0] fifo_din;
    logic [2:0] write_enb, vld_out, soft_rst;

    int n_cmp = 0;
    int n_err = 0;
    bit env_rand = 0;
    bit mon_on   = 1;
    int cyc      = 0;

    logic [9:0] exp_q[$];
    bit         err_q[$];
    logic [7:0] pkt[$];

    router_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .read_en     (read_en),
        .busy        (busy),
        .fifo_din    (fifo_din),
        .write_enb   (write_enb),
        .lfd_state   (lfd_state),
        .vld_out     (vld_out),
        .soft_rst    (soft_rst),
        .parity_done (parity_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic give_up(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no progress within cycle budget (t=%0t)", name, $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    function automatic logic [1:0] port_of(input logic [2:0] oh);
        case (oh)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Random FIFO status while the random phase runs; reads are forced
    // periodically so no output ever times out here.
    always @(negedge clk) begin
        cyc++;
        if (env_rand) begin
            for (int i = 0; i < 3; i++) begin
                fifo_empty[i] = (int'($urandom_range(0, 9)) < 7);
                fifo_full[i]  = (int'($urandom_range(0, 3)) == 0);
            end
            read_en = (cyc % 16 == 0) ? 3'b111 : 3'($urandom);
        end
    end

    // Scoreboard monitor: a write completes on a clock where write_enb targets a non-full FIFO.
    initial begin : monitor
        bit         pd_prev;
        logic [9:0] e;
        bit         eb;
        pd_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && write_enb != 3'b000) begin
                check("write_onehot", 32'($onehot(write_enb)), 32'd1);
                if (mon_on && (write_enb & fifo_full) == 3'b000) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_write: got port %0d byte 0x%0h, required none", port_of(write_enb), fifo_din);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_write", 32'({port_of(write_enb), fifo_din}), 32'(e));
                    end
                end
            end
            if (mon_on && parity_done && !pd_prev) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_parity_done: got 1, required 0");
                end else begin
                    eb = err_q.pop_front();
                    check("sb_err", 32'(err), 32'(eb));
                end
            end
            pd_prev = parity_done;
        end
    end

    task automatic build_pkt(input logic [1:0] addr, input int len, input bit bad);
        logic [7:0] x, b;
        pkt.delete();
        x = {6'(len), addr};
        pkt.push_back(x);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pkt.push_back(b);
            x ^= b;
        end
        if (bad) x ^= 8'($urandom_range(1, 255));
        pkt.push_back(x);
    endtask

    task automatic drive_byte(input logic [7:0] b, input int stall_pct);
        int tries;
        bit done;
        tries = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) begin
                pkt_valid = 1'b0;
                data_in   = 8'($urandom);
            end else begin
                pkt_valid = 1'b1;
                data_in   = b;
                #1;
                if (!busy) done = 1;
            end
            tries++;
            if (!done && tries > 400) give_up("drive_timeout");
        end
    endtask

    // Reference: non-drop packets land in FIFO addr byte-for-byte; err = xor(header..payload) != parity.
    task automatic send_pkt(input int stall_pct);
        logic [7:0] x;
        logic [1:0] a;
        x = 8'd0;
        for (int i = 0; i < pkt.size() - 1; i++) x ^= pkt[i];
        a = pkt[0][1:0];
        if (a != 2'b11) begin
            foreach (pkt[i]) exp_q.push_back({a, pkt[i]});
            err_q.push_back(x != pkt[pkt.size() - 1]);
        end
        foreach (pkt[i]) drive_byte(pkt[i], stall_pct);
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic wait_lfd(output bit found);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (lfd_state) found = 1;
        end
        check("lfd_seen", 32'(found), 32'd1);
    endtask

    task automatic chk_stream;
        bit f;
        wait_lfd(f);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            check("stream_we", 32'(write_enb), 32'h2);
            check("stream_din", 32'(fifo_din), 32'(pkt[k]));
        end
        @(negedge clk);
        #2;
        check("stream_parity_done", 32'(parity_done), 32'd1);
        check("stream_err", 32'(err), 32'd0);
        check("stream_we_idle", 32'(write_enb), 32'd0);
    endtask

    task automatic chk_wait;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_we", 32'(write_enb), 32'd0);
            check("wait_err_held", 32'(err), 32'd1);
        end
        @(negedge clk);
        fifo_empty = 3'b111;
        #2;
        check("wait_lfd", 32'(lfd_state), 32'd1);
        check("wait_busy_rel", 32'(busy), 32'd0);
        @(negedge clk);
        #2;
        check("wait_err_clr", 32'(err), 32'd0);
        check("wait_pd_clr", 32'(parity_done), 32'd0);
        check("wait_we_hdr", 32'(write_enb), 32'h4);
    endtask

    task automatic chk_stall;
        bit f;
        wait_lfd(f);
        repeat (2) @(negedge clk);
        @(negedge clk);
        fifo_full = 3'b001;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            check("stall_we", 32'(write_enb), 32'h1);
            check("stall_din", 32'(fifo_din), 32'(pkt[2]));
            check("stall_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        fifo_full = 3'b000;
        #2;
        check("stall_busy_rel", 32'(busy), 32'd0);
    endtask

    task automatic chk_drop;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            check("drop_busy", 32'(busy), 32'd0);
            check("drop_we", 32'(write_enb), 32'd0);
        end
    endtask

    task automatic chk_timer;
        @(negedge clk);
        fifo_empty = 3'b111;
        read_en    = 3'b000;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) fifo_empty = 3'b110;
            #2;
            check("sr_plain", 32'(soft_rst[0]), 32'(c == 31));
        end
        @(negedge clk);
        fifo_empty = 3'b111;
        @(negedge clk);
        for (int c = 1; c <= 62; c++) begin
            @(negedge clk);
            if (c == 1) fifo_empty = 3'b110;
            if (c == 29) read_en = 3'b001;
            if (c == 30) read_en = 3'b000;
            #2;
            check("sr_read", 32'(soft_rst[0]), 32'(c == 60));
        end
        @(negedge clk);
        fifo_empty = 3'b111;
        read_en    = 3'b111;
    endtask

    task automatic chk_reset_mid;
        mon_on = 0;
        @(negedge clk);
        pkt_valid = 1'b1;
        data_in   = 8'h15;
        @(negedge clk);
        data_in = 8'hAA;
        @(negedge clk);
        data_in = 8'hBB;
        @(negedge clk);
        pkt_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_din", 32'(fifo_din), 32'd0);
        check("rstm_we", 32'(write_enb), 32'd0);
        check("rstm_lfd", 32'(lfd_state), 32'd0);
        check("rstm_sr", 32'(soft_rst), 32'd0);
        check("rstm_pd", 32'(parity_done), 32'd0);
        check("rstm_err", 32'(err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            check("rstm_no_write", 32'(write_enb), 32'd0);
        end
        mon_on = 1;
    endtask

    initial begin : watchdog
        #500000;
        give_up("watchdog");
    end

    initial begin : main
        int  a, len;
        bit  bad;
        rst        = 1'b1;
        pkt_valid  = 1'b0;
        data_in    = 8'd0;
        fifo_full  = 3'b000;
        fifo_empty = 3'b101;
        read_en    = 3'b111;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_din", 32'(fifo_din), 32'd0);
        check("rst_we", 32'(write_enb), 32'd0);
        check("rst_sr", 32'(soft_rst), 32'd0);
        check("rst_pd", 32'(parity_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_vld_out", 32'(vld_out), 32'h2);
        @(negedge clk);
        rst        = 1'b0;
        fifo_empty = 3'b111;
        repeat (2) @(negedge clk);

        // good packet to FIFO1
        pkt.delete();
        pkt.push_back(8'h0D); pkt.push_back(8'h11); pkt.push_back(8'h22);
        pkt.push_back(8'h33); pkt.push_back(8'h0D);
        fork
            send_pkt(0);
            chk_stream();
        join
        repeat (2) @(negedge clk);

        // same packet with a wrong parity byte
        pkt[4] = 8'h00;
        send_pkt(0);
        repeat (2) @(negedge clk);
        #2;
        check("badpar_pd", 32'(parity_done), 32'd1);
        check("badpar_err", 32'(err), 32'd1);

        // zero-length packet to FIFO2 waiting for an empty FIFO
        @(negedge clk);
        fifo_empty = 3'b011;
        pkt.delete();
        pkt.push_back(8'h02); pkt.push_back(8'h02);
        fork
            send_pkt(0);
            chk_wait();
        join
        repeat (3) @(negedge clk);

        // output backpressure mid-payload
        build_pkt(2'd0, 4, 1'b0);
        fork
            send_pkt(0);
            chk_stall();
        join
        repeat (4) @(negedge clk);

        chk_timer();
        repeat (2) @(negedge clk);

        // address 3 packet is consumed without writes
        build_pkt(2'd3, 2, 1'b0);
        fork
            send_pkt(0);
            chk_drop();
        join
        repeat (3) @(negedge clk);

        chk_reset_mid();
        build_pkt(2'd1, 1, 1'b0);
        send_pkt(0);
        repeat (3) @(negedge clk);

        env_rand = 1;
        for (int p = 0; p < 40; p++) begin
            a   = int'($urandom_range(0, 3));
            len = (int'($urandom_range(0, 9)) == 0) ? 63 : int'($urandom_range(0, 12));
            bad = (int'($urandom_range(0, 3)) == 0);
            build_pkt(2'(a), len, bad);
            send_pkt(20);
        end
        @(negedge clk);
        env_rand   = 0;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_en    = 3'b111;
        for (int k = 0; k < 300 && (exp_q.size() != 0 || err_q.size() != 0); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_writes", 32'(exp_q.size()), 32'd0);
        check("drain_parity", 32'(err_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
